// File: rtl/zion_riscv_bits_op_exec_pipe_if.sv
// Issue/writeback handshake bundle for the bitwise execution unit.
// DUT side uses the slave modport; the producer/consumer side uses master.
interface zion_riscv_bits_op_exec_pipe_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] s1;
  logic [XLEN-1:0] s2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rslt;
  logic            busy;

  modport slave (
    input  req_valid, op, s1, s2, rsp_ready,
    output req_ready, rsp_valid, rslt, busy
  );

  modport master (
    output req_valid, op, s1, s2, rsp_ready,
    input  req_ready, rsp_valid, rslt, busy
  );
endinterface

// File: rtl/zion_riscv_bits_op_exec_pipe.sv
// RISC-V bitwise EX unit: 1-cycle logic ops, iterative CPOP/CLZ/CTZ.
// Count ops are built only when ZION_RISCV_BITSEX_CNT_EN is defined.
module zion_riscv_bits_op_exec_pipe #(
  parameter int RV64     = 0,
  parameter int CNT_STEP = 8
) (
  input  logic clk,
  input  logic rst,
  zion_riscv_bits_op_exec_pipe_if.slave bus
);
  localparam int XLEN = 32 * (RV64 + 1);

  logic            rsp_valid;
  logic [XLEN-1:0] rslt;
  logic [XLEN-1:0] s1, s2, logic_res;
  logic            idle, accept, is_cnt, cnt_done;
  logic [XLEN-1:0] cnt_rslt;

  assign s1 = bus.s1;
  assign s2 = bus.s2;

  always_comb begin
    logic_res = '0;
    case (bus.op)
      4'd0:    logic_res = s1 & s2;
      4'd1:    logic_res = s1 | s2;
      4'd2:    logic_res = s1 ^ s2;
      4'd3:    logic_res = s1 & ~s2;
      4'd4:    logic_res = s1 | ~s2;
      4'd5:    logic_res = ~(s1 ^ s2);
      default: logic_res = '0;
    endcase
  end

  assign bus.req_ready = idle && (!rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef ZION_RISCV_BITSEX_CNT_EN
  localparam int N  = XLEN / CNT_STEP;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [1:0] K_CPOP = 2'd0, K_CLZ = 2'd1, K_CTZ = 2'd2;

  typedef enum logic {IDLE, CNT} state_t;
  state_t          state, state_nx;
  logic [XLEN-1:0] sh;
  logic [CW-1:0]   acc, acc_nx;
  logic            found, found_nx, last;
  logic [1:0]      kind;
  logic [IW-1:0]   idx;
  logic [CNT_STEP-1:0] chunk;

  function automatic logic [CW-1:0] chunk_count(input logic [1:0] k,
                                                 input logic [CNT_STEP-1:0] c);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < CNT_STEP; i++) begin
      case (k)
        K_CPOP: n = n + CW'(c[i]);
        K_CLZ: begin
          if (!hit && c[CNT_STEP-1-i]) hit = 1'b1;
          else if (!hit)               n = n + CW'(1);
        end
        default: begin
          if (!hit && c[i]) hit = 1'b1;
          else if (!hit)    n = n + CW'(1);
        end
      endcase
    end
    return n;
  endfunction

  // CLZ walks the operand MSB-first, everything else LSB-first.
  assign chunk  = (kind == K_CLZ) ? sh[XLEN-1 -: CNT_STEP] : sh[CNT_STEP-1:0];
  assign last   = (idx == IW'(N - 1));
  assign is_cnt = (bus.op == 4'd6) || (bus.op == 4'd7) || (bus.op == 4'd8);
  assign idle   = (state == IDLE);
  assign bus.busy = !idle;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    found_nx = found;
    case (state)
      IDLE: if (accept && is_cnt) state_nx = CNT;
      CNT: begin
        if (kind == K_CPOP || !found) acc_nx = acc + chunk_count(kind, chunk);
        found_nx = found | (chunk != '0);
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh    <= '0;
      acc   <= '0;
      found <= 1'b0;
      kind  <= K_CPOP;
      idx   <= '0;
    end else if (state == IDLE) begin
      if (accept && is_cnt) begin
        sh    <= s1;
        acc   <= '0;
        found <= 1'b0;
        kind  <= 2'(bus.op - 4'd6);
        idx   <= '0;
      end
    end else begin
      sh    <= (kind == K_CLZ) ? (sh << CNT_STEP) : (sh >> CNT_STEP);
      acc   <= acc_nx;
      found <= found_nx;
      idx   <= idx + IW'(1);
    end
  end

  assign cnt_done = (state == CNT) && last;
  assign cnt_rslt = {{(XLEN-CW){1'b0}}, acc_nx};
`else
  assign is_cnt   = 1'b0;
  assign idle     = 1'b1;
  assign cnt_done = 1'b0;
  assign cnt_rslt = '0;
  assign bus.busy = 1'b0;
`endif

  // A count accept drains any prior result, so completion never collides with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rslt      <= '0;
    end else if (cnt_done) begin
      rsp_valid <= 1'b1;
      rslt      <= cnt_rslt;
    end else if (accept && !is_cnt) begin
      rsp_valid <= 1'b1;
      rslt      <= logic_res;
    end else if (accept || bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rslt      = rslt;
endmodule
